// File: rtl/fx_addsub_pipe_pkg.sv
// rtl/fx_addsub_pipe_pkg.sv - shared mode encoding and parameter legality for fx_addsub_pipe
package fx_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;

  function automatic bit params_ok(input int in_w, input int in_frac, input int out_w,
                                   input int out_frac, input int latency);
    return (in_w >= 2) && (in_frac >= 0) && (in_frac < in_w) && (out_w >= 2) &&
           (out_frac >= 0) && (latency >= LATENCY_MIN) && (latency <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/fx_addsub_pipe_if.sv
// rtl/fx_addsub_pipe_if.sv - operand/result handshake bundle for fx_addsub_pipe
interface fx_addsub_pipe_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 13
);
  logic             i_valid;
  logic             i_ready;
  logic             i_mode;
  logic [IN_W-1:0]  i_data_1;
  logic [IN_W-1:0]  i_data_2;
  logic             o_valid;
  logic             o_ready;
  logic [OUT_W-1:0] o_data;
  logic             o_ovf;

  modport master (
    output i_valid, i_mode, i_data_1, i_data_2, o_ready,
    input  i_ready, o_valid, o_data, o_ovf
  );

  modport slave (
    input  i_valid, i_mode, i_data_1, i_data_2, o_ready,
    output i_ready, o_valid, o_data, o_ovf
  );
endinterface

// File: rtl/fx_addsub_pipe_round_sat.sv
// rtl/fx_addsub_pipe_round_sat.sv - fx_round_sat: align, round half up, saturate or wrap
module fx_round_sat #(
  parameter int IN_W     = 13,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 13,
  parameter int OUT_FRAC = 8,
  parameter int SAT_EN   = 1
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);
  localparam int LSH = (OUT_FRAC > IN_FRAC) ? OUT_FRAC - IN_FRAC : 0;
  localparam int RSH = (IN_FRAC > OUT_FRAC) ? IN_FRAC - OUT_FRAC : 0;
  // One spare bit keeps the rounding add from wrapping before the shift.
  localparam int AW  = IN_W + LSH + 1;
  localparam int CW  = (AW > OUT_W) ? AW : OUT_W;
  localparam logic signed [CW-1:0] MAX_V = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] MIN_V = ~MAX_V;

  logic signed [CW-1:0] ext;
  logic signed [CW-1:0] aligned;

  assign ext = {{(CW-IN_W){in_data[IN_W-1]}}, in_data};

  if (RSH > 0) begin : g_round
    localparam logic signed [CW-1:0] HALF = CW'(1) << (RSH - 1);
    assign aligned = (ext + HALF) >>> RSH;
  end else begin : g_widen
    assign aligned = ext <<< LSH;
  end

  always_comb begin
    out_ovf  = (aligned > MAX_V) || (aligned < MIN_V);
    out_data = aligned[OUT_W-1:0];
    if ((SAT_EN != 0) && out_ovf) begin
      out_data = (aligned > MAX_V) ? MAX_V[OUT_W-1:0] : MIN_V[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/fx_addsub_pipe.sv
// rtl/fx_addsub_pipe.sv - pipelined fixed-point add/sub with rounding, saturation and stats
module fx_addsub_pipe
  import fx_pkg::*;
#(
  parameter int IN_W     = 12,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 13,
  parameter int OUT_FRAC = 8,
  parameter int LATENCY  = 1,
  parameter int SAT_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  fx_addsub_pipe_if.slave       bus,
  input  logic                  i_clr_sticky,
  output logic                  o_ovf_sticky,
  output logic [15:0]           o_count
);
  localparam int W = IN_W + 1;

  if (!params_ok(IN_W, IN_FRAC, OUT_W, OUT_FRAC, LATENCY)) begin : g_bad_params
    $error("fx_addsub_pipe: illegal parameter set");
  end

  logic             adv;
  logic             xfer;
  logic [W-1:0]     full;
  logic [OUT_W-1:0] rs_data;
  logic             rs_ovf;

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] ovf_q, ovf_d;
  logic [OUT_W-1:0]   data_q [LATENCY];
  logic [OUT_W-1:0]   data_d [LATENCY];
  logic               sticky_q, sticky_d;
  logic [15:0]        count_q, count_d;

  // The whole pipe moves as one; a stalled output freezes every stage, bubbles included.
  assign adv         = !valid_q[LATENCY-1] || bus.o_ready;
  assign xfer        = valid_q[LATENCY-1] && bus.o_ready;
  assign bus.i_ready = adv || rst;

  always_comb begin
    if (bus.i_mode == MODE_SUB) begin
      full = {bus.i_data_1[IN_W-1], bus.i_data_1} - {bus.i_data_2[IN_W-1], bus.i_data_2};
    end else begin
      full = {bus.i_data_1[IN_W-1], bus.i_data_1} + {bus.i_data_2[IN_W-1], bus.i_data_2};
    end
  end

  fx_round_sat #(
    .IN_W     (W),
    .IN_FRAC  (IN_FRAC),
    .OUT_W    (OUT_W),
    .OUT_FRAC (OUT_FRAC),
    .SAT_EN   (SAT_EN)
  ) u_round_sat (
    .in_data  (full),
    .out_data (rs_data),
    .out_ovf  (rs_ovf)
  );

  always_comb begin
    valid_d = valid_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    if (adv) begin
      valid_d[0] = bus.i_valid;
      ovf_d[0]   = rs_ovf;
      data_d[0]  = rs_data;
      for (int k = 1; k < LATENCY; k++) begin
        valid_d[k] = valid_q[k-1];
        ovf_d[k]   = ovf_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  // A clear and a new overflow in the same cycle leave the flag set.
  always_comb begin
    sticky_d = i_clr_sticky ? 1'b0 : sticky_q;
    if (xfer && ovf_q[LATENCY-1]) begin
      sticky_d = 1'b1;
    end
    count_d = count_q + 16'(xfer);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      ovf_q    <= '0;
      sticky_q <= 1'b0;
      count_q  <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign bus.o_valid   = valid_q[LATENCY-1];
  assign bus.o_data    = data_q[LATENCY-1];
  assign bus.o_ovf     = ovf_q[LATENCY-1];
  assign o_ovf_sticky  = sticky_q;
  assign o_count       = count_q;
endmodule

// File: tb/tb_fx_addsub_pipe.sv
// tb/tb_fx_addsub_pipe.sv - self-checking bench for fx_addsub_pipe over four parameter sets
module tb_fx_addsub_pipe;
  logic        clk;
  logic        rst;
  logic        v, md, ordy, clr;
  logic [11:0] a, b;
  logic        stk0, stk1, stk2, stk3;
  logic [15:0] cnt0, cnt1, cnt2, cnt3;
  int          n_chk, n_err, cyc, sent;

  typedef struct {
    longint v;
    int     cyc;
    int     st;
  } ent_t;

  ent_t   sb [4][$];
  int     xfers [4];
  int     stalls [4];
  bit     held [4];
  bit     stk_m [4];
  longint held_v [4];

  fx_addsub_pipe_if #(.IN_W(12), .OUT_W(13)) b0 ();
  fx_addsub_pipe_if #(.IN_W(12), .OUT_W(12)) b1 ();
  fx_addsub_pipe_if #(.IN_W(12), .OUT_W(12)) b2 ();
  fx_addsub_pipe_if #(.IN_W(12), .OUT_W(13)) b3 ();

  assign {b0.i_valid, b0.i_mode, b0.i_data_1, b0.i_data_2, b0.o_ready} = {v, md, a, b, ordy};
  assign {b1.i_valid, b1.i_mode, b1.i_data_1, b1.i_data_2, b1.o_ready} = {v, md, a, b, ordy};
  assign {b2.i_valid, b2.i_mode, b2.i_data_1, b2.i_data_2, b2.o_ready} = {v, md, a, b, ordy};
  assign {b3.i_valid, b3.i_mode, b3.i_data_1, b3.i_data_2, b3.o_ready} = {v, md, a, b, ordy};

  fx_addsub_pipe #(.IN_W(12), .IN_FRAC(8), .OUT_W(13), .OUT_FRAC(8), .LATENCY(1), .SAT_EN(1)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave), .i_clr_sticky(clr), .o_ovf_sticky(stk0), .o_count(cnt0));
  fx_addsub_pipe #(.IN_W(12), .IN_FRAC(8), .OUT_W(12), .OUT_FRAC(8), .LATENCY(3), .SAT_EN(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave), .i_clr_sticky(clr), .o_ovf_sticky(stk1), .o_count(cnt1));
  fx_addsub_pipe #(.IN_W(12), .IN_FRAC(8), .OUT_W(12), .OUT_FRAC(8), .LATENCY(2), .SAT_EN(0)) u2 (
    .clk(clk), .rst(rst), .bus(b2.slave), .i_clr_sticky(clr), .o_ovf_sticky(stk2), .o_count(cnt2));
  fx_addsub_pipe #(.IN_W(12), .IN_FRAC(8), .OUT_W(13), .OUT_FRAC(6), .LATENCY(1), .SAT_EN(1)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave), .i_clr_sticky(clr), .o_ovf_sticky(stk3), .o_count(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed arithmetic, floor((x + 2^(s-1)) / 2^s) rounding, then range clamp or wrap.
  function automatic longint ref_calc(input int ow, input int of, input int sat, input logic m,
                                      input logic [11:0] x, input logic [11:0] y);
    longint full, al, mx, mn, d;
    bit     ovf;
    full = m ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y));
    if (of < 8) al = (full + (longint'(1) <<< (7 - of))) >>> (8 - of);
    else        al = full * (longint'(1) <<< (of - 8));
    mx  = (longint'(1) <<< (ow - 1)) - 1;
    mn  = -mx - 1;
    ovf = (al > mx) || (al < mn);
    d   = al;
    if (ovf && sat != 0) d = (al > mx) ? mx : mn;
    return (longint'(ovf) <<< 16) | (d & ((longint'(1) <<< ow) - 1));
  endfunction

  task automatic mon(input int k, input int lat, input int ow, input int of, input int sat,
                     input logic iv, input logic ir, input logic m, input logic [11:0] x,
                     input logic [11:0] y, input logic ov, input logic [15:0] od, input logic oo,
                     input logic stk, input logic [15:0] cnt);
    ent_t   e;
    longint got;
    bit     nxt;
    got = (longint'(oo) << 16) | longint'(od);
    if (rst) begin
      sb[k].delete();
      xfers[k] = 0;
      stk_m[k] = 1'b0;
      held[k]  = 1'b0;
      return;
    end
    chk($sformatf("u%0d.i_ready", k), ir, !ov || ordy);
    chk($sformatf("u%0d.sticky", k), stk, stk_m[k]);
    chk($sformatf("u%0d.count", k), cnt, xfers[k] & 16'hFFFF);
    if (held[k]) chk($sformatf("u%0d.hold", k), ov ? got : -1, held_v[k]);
    if (sb[k].size() == 0) chk($sformatf("u%0d.o_valid_idle", k), ov, 0);
    nxt = clr ? 1'b0 : stk_m[k];
    if (ov && ordy && sb[k].size() > 0) begin
      e = sb[k].pop_front();
      chk($sformatf("u%0d.data", k), got, e.v);
      chk($sformatf("u%0d.latency", k), cyc - e.cyc, lat + stalls[k] - e.st);
      xfers[k]++;
      if (e.v[16]) nxt = 1'b1;
    end
    stk_m[k]  = nxt;
    held[k]   = ov && !ordy;
    held_v[k] = got;
    if (held[k]) stalls[k]++;
    if (iv && ir) sb[k].push_back('{ref_calc(ow, of, sat, m, x, y), cyc, stalls[k]});
  endtask

  always @(negedge clk) mon(0, 1, 13, 8, 1, b0.i_valid, b0.i_ready, b0.i_mode, b0.i_data_1, b0.i_data_2,
                            b0.o_valid, 16'(b0.o_data), b0.o_ovf, stk0, cnt0);
  always @(negedge clk) mon(1, 3, 12, 8, 1, b1.i_valid, b1.i_ready, b1.i_mode, b1.i_data_1, b1.i_data_2,
                            b1.o_valid, 16'(b1.o_data), b1.o_ovf, stk1, cnt1);
  always @(negedge clk) mon(2, 2, 12, 8, 0, b2.i_valid, b2.i_ready, b2.i_mode, b2.i_data_1, b2.i_data_2,
                            b2.o_valid, 16'(b2.o_data), b2.o_ovf, stk2, cnt2);
  always @(negedge clk) mon(3, 1, 13, 6, 1, b3.i_valid, b3.i_ready, b3.i_mode, b3.i_data_1, b3.i_data_2,
                            b3.o_valid, 16'(b3.o_data), b3.o_ovf, stk3, cnt3);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [11:0] x, input logic [11:0] y);
    v = 1'b1; md = m; a = x; b = y;
    step();
    v = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] xs [4];
    int          es [4];
    xs = '{12'h001, 12'h002, 12'h003, 12'hFFE};
    es = '{0, 1, 1, 0};
    rst = 1'b1; v = 1'b0; md = 1'b0; a = '0; b = '0; ordy = 1'b1; clr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset.u0", {b0.o_valid, b0.o_ovf, b0.i_ready, stk0, b0.o_data, cnt0}, {4'b0010, 13'h0, 16'h0});
    chk("reset.u1", {b1.o_valid, b1.o_ovf, b1.i_ready, stk1, b1.o_data, cnt1}, {4'b0010, 12'h0, 16'h0});

    send(1'b0, 12'h7FF, 12'h7FF);
    chk("add_max.u0", {b0.o_valid, b0.o_ovf, b0.o_data}, {2'b10, 13'h0FFE});
    repeat (3) step();

    send(1'b0, 12'h7FF, 12'h001);
    step();
    chk("ovf_wrap.u2", {b2.o_valid, b2.o_ovf, b2.o_data}, {2'b11, 12'h800});
    step();
    chk("ovf_sat.u1", {b1.o_valid, b1.o_ovf, b1.o_data}, {2'b11, 12'h7FF});
    step();
    chk("ovf_sticky.u1", stk1, 1);
    repeat (2) step();

    send(1'b1, 12'h800, 12'h001);
    chk("sub_min.u0", {b0.o_valid, b0.o_ovf, b0.o_data}, {2'b10, 13'h17FF});
    repeat (3) step();

    for (int i = 0; i < 4; i++) begin
      send(1'b0, xs[i], 12'h000);
      chk($sformatf("round%0d.u3", i), {b3.o_valid, b3.o_ovf, b3.o_data}, {2'b10, 13'(es[i])});
    end
    repeat (3) step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    sent = 0;
    for (int j = 0; j < 20; j++) begin
      ordy = !(j >= 3 && j < 8);
      v    = (sent < 6);
      md   = 1'($urandom);
      a    = 12'($urandom);
      b    = 12'($urandom);
      @(negedge clk);
      if (v && b1.i_ready) sent++;
      step();
    end
    v = 1'b0; ordy = 1'b1;
    step();
    chk("burst.count.u1", cnt1, 6);

    for (int j = 0; j < 600; j++) begin
      v    = ($urandom_range(0, 3) != 0);
      md   = 1'($urandom);
      a    = ($urandom_range(0, 3) == 0) ? 12'h7FF : 12'($urandom);
      b    = ($urandom_range(0, 3) == 0) ? 12'h800 : 12'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      step();
    end
    v = 1'b0; ordy = 1'b1; clr = 1'b0;
    repeat (5) step();

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr.u2", stk2, 0);
    send(1'b0, 12'h7FF, 12'h001);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_and_set.u2", stk2, 1);

    v = 1'b1; md = 1'b0; a = 12'h7FF; b = 12'h001;
    repeat (3) step();
    v = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst.u1", {b1.o_valid, stk1, cnt1}, 18'h0);
    chk("midrst.u2", {b2.o_valid, stk2, cnt2}, 18'h0);
    chk("midrst.valid", {b0.o_valid, b3.o_valid}, 2'b00);
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fx_addsub_pipe.md
FX_ADDSUB_PIPE -- requirements
Module: fx_addsub_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 12, input word width (signed two's complement).
REQ-002 SHALL have parameter IN_FRAC, default 8, input fractional bits (both operands).
REQ-003 SHALL have parameter OUT_W, default 13, output word width.
REQ-004 SHALL have parameter OUT_FRAC, default 8, output fractional bits.
REQ-005 SHALL have parameter LATENCY, default 1, pipeline depth, legal range 1..8.
REQ-006 SHALL have parameter SAT_EN, default 1: 1 = saturate, 0 = wrap.
REQ-007 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-009 SHALL have ports i_valid in 1 and i_ready out 1  input handshake.
REQ-010 SHALL have port i_mode  in  1  0 = data_1 + data_2, 1 = data_1 - data_2; sampled with the data.
REQ-011 SHALL have ports i_data_1, i_data_2  in  IN_W  operands.
REQ-012 SHALL have ports o_valid out 1 and o_ready in 1  output handshake.
REQ-013 SHALL have port o_data  out  OUT_W  result.
REQ-014 SHALL have port o_ovf  out  1  overflow of the sample on o_data, qualified by o_valid.
REQ-015 SHALL have ports i_clr_sticky in 1 and o_ovf_sticky out 1  sticky overflow flag and its clear.
REQ-016 SHALL have port o_count  out  16  count of completed output transfers.

Function
REQ-017 SHALL accept a sample when i_valid && i_ready.
REQ-018 SHALL compute the full-precision result in IN_W+1 bits with sign extension; no loss before alignment.
REQ-019 SHALL align to OUT_FRAC: OUT_FRAC < IN_FRAC → add 2^(s-1), then arithmetic right shift by s = IN_FRAC-OUT_FRAC (round half up); OUT_FRAC >= IN_FRAC → left shift with zero fill.
REQ-020 SHALL, when the aligned value exceeds OUT_W range, output the signed max/min if SAT_EN=1, else the low OUT_W bits; o_ovf=1 in both cases.
REQ-021 SHALL use a global advance signal adv = !o_valid || o_ready; all stages shift only when adv=1; i_ready = adv.
REQ-022 SHALL present a sample accepted in cycle t on o_valid/o_data/o_ovf in cycle t+LATENCY when no stall occurs; stalls add cycles 1:1.
REQ-023 SHALL hold o_data, o_ovf and o_valid stable while o_valid && !o_ready.
REQ-024 SHALL propagate bubbles; o_valid=0 for stages holding no accepted sample.
REQ-025 SHALL never drop, duplicate or reorder samples.
REQ-026 SHALL set o_ovf_sticky in the cycle after a transfer with o_ovf=1; i_clr_sticky clears it; a simultaneous set and clear leaves it set.
REQ-027 SHALL increment o_count on each o_valid && o_ready, wrapping from 0xFFFF to 0x0000.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear all stage valids, o_data, o_ovf, o_ovf_sticky and o_count to 0, with o_valid=0 from the following cycle.
REQ-029 SHALL discard all in-flight samples on reset mid-stream; no output of pre-reset data after reset.
REQ-030 SHALL drive i_ready=1 during and immediately after reset (no o_valid held).

Structure
REQ-031 SHALL place the mode encoding constants (MODE_ADD=0, MODE_SUB=1) and parameter range checks in shared package fx_pkg.
REQ-032 SHALL implement align/round/saturate in sub-module fx_round_sat (params IN_W+1, IN_FRAC, OUT_W, OUT_FRAC, SAT_EN), combinational, instantiated once before stage 1.

Verification (IN_W=12, IN_FRAC=8 unless stated)
REQ-033 SHALL cover: default params, add 0x7FF+0x7FF → o_data=0x0FFE, o_ovf=0, one cycle later.
REQ-034 SHALL cover: OUT_W=12, add 0x7FF+0x001 → 0x7FF with o_ovf=1 and sticky set if SAT_EN=1; 0x800 with o_ovf=1 if SAT_EN=0.
REQ-035 SHALL cover: default params, sub 0x800-0x001 → 0x17FF (-2049), o_ovf=0.
REQ-036 SHALL cover: OUT_FRAC=6, add x+0 for x = 0x001, 0x002, 0x003, 0xFFE → 0, 1, 1, 0.
REQ-037 SHALL cover: LATENCY=3, 6 back-to-back samples, o_ready low 5 cycles mid-burst → i_ready low exactly while o_valid && !o_ready, all 6 outputs in order, o_count=6.
REQ-038 SHALL cover: rst pulse with 3 samples in flight → o_valid=0 next cycle, o_count=0, sticky cleared; clr+set same cycle → sticky=1.
